// File: rtl/frag_depth_writer.sv
// Fragment sink: bounds check, depth test against a fixed-latency depth buffer,
// and RGBA8888 pixel write with optional depth write-back.
package celery_pkg;
   typedef logic signed [31:0] fp32_t;
   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      fp32_t              z;
      fp32_t              r;
      fp32_t              g;
      fp32_t              b;
      fp32_t              a;
      fp32_t              u;
      fp32_t              v;
   } frag_t;
endpackage

module frag_depth_writer
   import celery_pkg::*;
#(
   parameter int FB_WIDTH  = 640,
   parameter int FB_HEIGHT = 480,
   parameter int ADDR_W    = 19,
   parameter int RD_LAT    = 2,
   parameter int FRAC_BITS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  frag_t             frag_in,
   input  logic              frag_valid,
   output logic              frag_ready,
   input  logic              depth_test_en,
   input  logic [1:0]        depth_func,
   input  logic              depth_write_en,
   output logic              z_rd_en,
   output logic [ADDR_W-1:0] z_rd_addr,
   input  logic [31:0]       z_rd_data,
   output logic              z_wr_en,
   output logic [ADDR_W-1:0] z_wr_addr,
   output logic [31:0]       z_wr_data,
   output logic              px_wr_en,
   output logic [ADDR_W-1:0] px_wr_addr,
   output logic [31:0]       px_wr_data,
   input  logic              px_wr_ready,
   output logic [31:0]       frags_passed,
   output logic [31:0]       frags_killed,
   output logic              busy
);

   localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_TEST  = 3'd3,
      S_WRITE = 3'd4
   } state_e;

   function automatic logic [7:0] to_unorm8(input logic signed [31:0] c);
      logic [39:0] prod;
      prod = 40'({1'b0, c[30:0]}) * 40'd255;
      if (c <= 32'sd0)
         return 8'd0;
      else if (c >= (32'sd1 <<< FRAC_BITS))
         return 8'd255;
      else
         return 8'(prod >> FRAC_BITS);
   endfunction

   function automatic logic depth_pass(input logic [1:0] func,
                                       input logic signed [31:0] z,
                                       input logic signed [31:0] zb);
      case (func)
         2'b00:   return 1'b0;
         2'b01:   return z < zb;
         2'b10:   return z <= zb;
         2'b11:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       z_q, z_d;
   logic [31:0]       px_data_q, px_data_d;
   logic              dte_q, dte_d;
   logic [1:0]        dfunc_q, dfunc_d;
   logic              dwe_q, dwe_d;
   logic [WCW-1:0]    wait_q, wait_d;
   logic [31:0]       passed_q, passed_d;
   logic [31:0]       killed_q, killed_d;
   logic              frag_ready_q, busy_q, z_rd_en_q, px_wr_en_q;

   logic signed [31:0] x_s, y_s, addr_full_s;
   logic               oob_s;
   logic               unused_s;

   assign x_s         = 32'(frag_in.x);
   assign y_s         = 32'(frag_in.y);
   assign oob_s       = (x_s < 32'sd0) || (y_s < 32'sd0) || (x_s >= FB_WIDTH) || (y_s >= FB_HEIGHT);
   assign addr_full_s = y_s * FB_WIDTH + x_s;
   assign unused_s    = ^{frag_in.u, frag_in.v, addr_full_s[31:ADDR_W]};

   // Next-state and datapath capture
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      z_d       = z_q;
      px_data_d = px_data_q;
      dte_d     = dte_q;
      dfunc_d   = dfunc_q;
      dwe_d     = dwe_q;
      wait_d    = wait_q;
      passed_d  = passed_q;
      killed_d  = killed_q;
      case (state_q)
         S_IDLE: begin
            if (frag_valid && frag_ready_q) begin
               addr_d    = addr_full_s[ADDR_W-1:0];
               z_d       = frag_in.z;
               px_data_d = {to_unorm8(frag_in.r), to_unorm8(frag_in.g),
                            to_unorm8(frag_in.b), to_unorm8(frag_in.a)};
               dte_d     = depth_test_en;
               dfunc_d   = depth_func;
               dwe_d     = depth_write_en;
               if (oob_s)
                  killed_d = killed_q + 32'd1;
               else if (depth_test_en)
                  state_d = S_READ;
               else
                  state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            wait_d = '0;
            if (RD_LAT == 1)
               state_d = S_TEST;
            else
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == WCW'(RD_LAT - 2))
               state_d = S_TEST;
            else
               wait_d = wait_q + 1'b1;
         end
         S_TEST: begin
            if (depth_pass(dfunc_q, z_q, z_rd_data)) begin
               state_d = S_WRITE;
            end else begin
               killed_d = killed_q + 32'd1;
               state_d  = S_IDLE;
            end
         end
         S_WRITE: begin
            if (px_wr_ready) begin
               passed_d = passed_q + 32'd1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_WRITE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and strobe registers; strobes follow the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         z_q          <= 32'd0;
         px_data_q    <= 32'd0;
         dte_q        <= 1'b0;
         dfunc_q      <= 2'b00;
         dwe_q        <= 1'b0;
         wait_q       <= '0;
         passed_q     <= 32'd0;
         killed_q     <= 32'd0;
         frag_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         z_rd_en_q    <= 1'b0;
         px_wr_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         z_q          <= z_d;
         px_data_q    <= px_data_d;
         dte_q        <= dte_d;
         dfunc_q      <= dfunc_d;
         dwe_q        <= dwe_d;
         wait_q       <= wait_d;
         passed_q     <= passed_d;
         killed_q     <= killed_d;
         frag_ready_q <= (state_d == S_IDLE);
         busy_q       <= (state_d != S_IDLE);
         z_rd_en_q    <= (state_d == S_READ);
         px_wr_en_q   <= (state_d == S_WRITE);
      end
   end

   // Depth write must coincide with the accepted pixel write, so it follows px_wr_ready directly
   assign z_wr_en      = px_wr_en_q && px_wr_ready && dwe_q;
   assign frag_ready   = frag_ready_q;
   assign busy         = busy_q;
   assign z_rd_en      = z_rd_en_q;
   assign z_rd_addr    = addr_q;
   assign z_wr_addr    = addr_q;
   assign z_wr_data    = z_q;
   assign px_wr_en     = px_wr_en_q;
   assign px_wr_addr   = addr_q;
   assign px_wr_data   = px_data_q;
   assign frags_passed = passed_q;
   assign frags_killed = killed_q;

endmodule
